// File: rtl/bus_pack_pkg.sv
// Shared types and helpers for the bus_pack_resp narrow-device responder.
package bus_pack_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_e;

    localparam logic [1:0] Mws8  = 2'd0;
    localparam logic [1:0] Mws16 = 2'd1;
    localparam logic [1:0] Mws32 = 2'd2;
    localparam logic [1:0] Mws64 = 2'd3;

    // Offset mask within a device word: W - 1.
    function automatic logic [2:0] width_mask(input logic [1:0] mws);
        logic [2:0] m;
        unique case (mws)
            Mws8:    m = 3'd0;
            Mws16:   m = 3'd1;
            Mws32:   m = 3'd3;
            default: m = 3'd7;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] width_bytes(input logic [1:0] mws);
        return {1'b0, width_mask(mws)} + 4'd1;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [2:0] lo, input logic [2:0] hi);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(lo) && i <= int'(hi)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_pack_lanes.sv
// Per-beat lane selection: byte enables for chunk c and whether it is the final beat.
module bus_pack_lanes
    import bus_pack_pkg::*;
(
    input  logic [2:0] c,
    input  logic [2:0] ba,
    input  logic [2:0] end_pos,
    input  logic [1:0] mws,
    output logic [7:0] be,
    output logic       last
);

    logic [2:0] chunk_top;
    logic [2:0] lo;
    logic [2:0] hi;

    always_comb begin
        // c is width-aligned, so OR-ing the offset mask gives c + W - 1 without carry.
        chunk_top = c | width_mask(mws);
        lo        = (c > ba) ? c : ba;
        hi        = (chunk_top < end_pos) ? chunk_top : end_pos;
        be        = byte_mask(lo, hi);
        last      = (chunk_top >= end_pos);
    end

endmodule

// File: rtl/bus_pack_resp.sv
// Splits one host-bus cycle into width-aligned device beats and gathers read bytes.
// Optional per-beat dev_ack timeout is enabled with `define BUS_PACK_TIMEOUT_EN.
module bus_pack_resp
    import bus_pack_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        req,
    input  logic        reads,
    input  logic [2:0]  ba,
    input  logic [3:0]  w,
    input  logic [1:0]  mws,
    input  logic        justify,
    input  logic [63:0] wdata,
    output logic        ack,
    output logic [63:0] rdata,
    output logic        busy,
    output logic        err,
    output logic        dev_strb,
    output logic        dev_we,
    output logic [2:0]  dev_ba,
    output logic [7:0]  dev_be,
    output logic [63:0] dev_wdata,
    input  logic [63:0] dev_rdata,
    input  logic        dev_ack
);

    state_e      state_q, state_d;
    logic [2:0]  ba_q, ba_d;
    logic [2:0]  end_q, end_d;
    logic [2:0]  c_q, c_d;
    logic [1:0]  mws_q, mws_d;
    logic        reads_q, reads_d;
    logic        justify_q, justify_d;
    logic        err_q, err_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rbuf_q, rbuf_d;

    logic [3:0]  n_bytes;
    logic [4:0]  end_full;
    logic [7:0]  beat_be;
    logic        beat_last;

`ifdef BUS_PACK_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      fill_lo;
    logic [7:0]      fill_mask;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign n_bytes  = (w == 4'd0) ? 4'd8 : w;
    assign end_full = {2'b00, ba} + {1'b0, n_bytes} - 5'd1;

    bus_pack_lanes u_lanes (
        .c       (c_q),
        .ba      (ba_q),
        .end_pos (end_q),
        .mws     (mws_q),
        .be      (beat_be),
        .last    (beat_last)
    );

    always_comb begin
        state_d   = state_q;
        ba_d      = ba_q;
        end_d     = end_q;
        c_d       = c_q;
        mws_d     = mws_q;
        reads_d   = reads_q;
        justify_d = justify_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
`ifdef BUS_PACK_TIMEOUT_EN
        cnt_d     = cnt_q;
        fill_lo   = (c_q > ba_q) ? c_q : ba_q;
        fill_mask = byte_mask(fill_lo, end_q);
`endif
        ack       = 1'b0;
        rdata     = '0;
        busy      = (state_q != StIdle);
        err       = 1'b0;
        dev_strb  = 1'b0;
        dev_we    = 1'b0;
        dev_ba    = '0;
        dev_be    = '0;
        dev_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    ba_d      = ba;
                    mws_d     = mws;
                    reads_d   = reads;
                    justify_d = justify;
                    wdata_d   = wdata;
                    rbuf_d    = '0;
                    // Runs past the phrase are clamped and reported as truncated.
                    err_d     = |end_full[4:3];
                    end_d     = (|end_full[4:3]) ? 3'd7 : end_full[2:0];
                    c_d       = ba & ~width_mask(mws);
                    state_d   = StIssue;
`ifdef BUS_PACK_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            StIssue: begin
                dev_strb  = 1'b1;
                dev_we    = ~reads_q;
                dev_ba    = c_q;
                dev_be    = beat_be;
                dev_wdata = wdata_q;
                if (dev_ack) begin
                    if (reads_q) begin
                        for (int i = 0; i < 8; i++) begin
                            if (beat_be[i]) rbuf_d[8*i +: 8] = dev_rdata[8*i +: 8];
                        end
                    end
                    if (beat_last) begin
                        state_d = StDone;
                    end else begin
                        c_d = c_q + width_mask(mws_q) + 3'd1;
                    end
`ifdef BUS_PACK_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    if (reads_q) begin
                        for (int i = 0; i < 8; i++) begin
                            if (fill_mask[i]) rbuf_d[8*i +: 8] = 8'hFF;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                ack     = 1'b1;
                err     = err_q;
                state_d = StIdle;
                if (reads_q) begin
                    rdata = justify_q ? (rbuf_q >> {ba_q, 3'b000}) : rbuf_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q   <= StIdle;
            ba_q      <= '0;
            end_q     <= '0;
            c_q       <= '0;
            mws_q     <= '0;
            reads_q   <= 1'b0;
            justify_q <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
`ifdef BUS_PACK_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ba_q      <= ba_d;
            end_q     <= end_d;
            c_q       <= c_d;
            mws_q     <= mws_d;
            reads_q   <= reads_d;
            justify_q <= justify_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
`ifdef BUS_PACK_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_pack_resp.sv
// Randomised bench for bus_pack_resp with a byte-range reference model of the beat sequence.
module tb_bus_pack_resp;

    logic        sys_clk = 1'b0;
    logic        resetl;
    logic        req;
    logic        reads;
    logic [2:0]  ba;
    logic [3:0]  w;
    logic [1:0]  mws;
    logic        justify;
    logic [63:0] wdata;
    logic        ack;
    logic [63:0] rdata;
    logic        busy;
    logic        err;
    logic        dev_strb;
    logic        dev_we;
    logic [2:0]  dev_ba;
    logic [7:0]  dev_be;
    logic [63:0] dev_wdata;
    logic [63:0] dev_rdata;
    logic        dev_ack;

    int checks = 0;
    int errors = 0;

    logic [63:0] last_rdata;
    logic        last_err;

    always #5 sys_clk = ~sys_clk;

    bus_pack_resp #(
        .TIMEOUT (4)
    ) dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .req       (req),
        .reads     (reads),
        .ba        (ba),
        .w         (w),
        .mws       (mws),
        .justify   (justify),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err),
        .dev_strb  (dev_strb),
        .dev_we    (dev_we),
        .dev_ba    (dev_ba),
        .dev_be    (dev_be),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack)
    );

    // One host cycle; the device side answers each beat after 0..max_wait wait states.
    task automatic run_txn(input logic t_reads, input logic [2:0] t_ba, input logic [3:0] t_w,
                           input logic [1:0] t_mws, input logic t_justify,
                           input logic [63:0] t_wdata, input int max_wait, input bit fixed,
                           input logic [63:0] fixed_rdata, input string name);
        int          n, e_full, e_end, wb, k, cycles, wait_left;
        bit          e_err, done;
        logic [7:0]  req_mask, chunk;
        logic [7:0]  exp_be[$];
        int          exp_ba[$];
        logic [63:0] mrb, exp_rdata;

        n      = (t_w == 4'd0) ? 8 : int'(t_w);
        e_full = int'(t_ba) + n - 1;
        e_err  = (e_full > 7);
        e_end  = e_err ? 7 : e_full;
        wb     = 1 << t_mws;
        req_mask = '0;
        for (int i = 0; i < 8; i++) if (i >= int'(t_ba) && i <= e_end) req_mask[i] = 1'b1;
        for (int c = 0; c < 8; c += wb) begin
            chunk = '0;
            for (int j = c; j < c + wb; j++) chunk[j] = 1'b1;
            if ((chunk & req_mask) != 8'h00) begin
                exp_ba.push_back(c);
                exp_be.push_back(chunk & req_mask);
            end
        end

        @(negedge sys_clk);
        req = 1'b1; reads = t_reads; ba = t_ba; w = t_w; mws = t_mws;
        justify = t_justify; wdata = t_wdata;
        @(negedge sys_clk);
        // Scramble the host inputs: they must be ignored once the cycle is accepted.
        req = 1'b0; reads = 1'($urandom); ba = 3'($urandom); w = 4'($urandom);
        mws = 2'($urandom); justify = 1'($urandom); wdata = {$urandom, $urandom};
        k = 0; cycles = 1; done = 0; mrb = '0;
        wait_left = $urandom_range(max_wait, 0);
        while (!done) begin
            if (ack === 1'b1) begin
                done = 1;
            end else if (cycles > 300) begin
                checks++; errors++;
                $display("FAIL %s ack_timeout: no ack after %0d cycles, required ack", name, cycles);
                done = 1;
            end else begin
                checks++;
                if (dev_strb !== 1'b1 || k >= exp_ba.size()) begin
                    errors++;
                    $display("FAIL %s strobe: dev_strb=%b beat=%0d, required strobe with %0d beats",
                             name, dev_strb, k, exp_ba.size());
                    dev_ack = 1'b0;
                end else begin
                    if (dev_ba !== 3'(exp_ba[k]) || dev_be !== exp_be[k] || dev_we !== ~t_reads
                        || dev_wdata !== t_wdata) begin
                        errors++;
                        $display("FAIL %s beat%0d: ba=%0d be=%h we=%b wd=%h, required ba=%0d be=%h we=%b wd=%h",
                                 name, k, dev_ba, dev_be, dev_we, dev_wdata, exp_ba[k], exp_be[k],
                                 ~t_reads, t_wdata);
                    end
                    if (wait_left == 0) begin
                        dev_ack   = 1'b1;
                        dev_rdata = fixed ? fixed_rdata : {$urandom, $urandom};
                        for (int i = 0; i < 8; i++)
                            if (exp_be[k][i]) mrb[8*i +: 8] = dev_rdata[8*i +: 8];
                        k++;
                        wait_left = $urandom_range(max_wait, 0);
                    end else begin
                        dev_ack   = 1'b0;
                        dev_rdata = {$urandom, $urandom};
                        wait_left--;
                    end
                end
                @(negedge sys_clk);
                cycles++;
            end
        end
        dev_ack = 1'b0;

        if (!t_reads) exp_rdata = '0;
        else if (t_justify) exp_rdata = mrb >> (8 * int'(t_ba));
        else exp_rdata = mrb;
        last_rdata = rdata;
        last_err   = err;

        checks++;
        if (k != exp_ba.size() || rdata !== exp_rdata || err !== e_err || busy !== 1'b1
            || dev_strb !== 1'b0) begin
            errors++;
            $display("FAIL %s done: beats=%0d rdata=%h err=%b busy=%b strb=%b, required beats=%0d rdata=%h err=%b busy=1 strb=0",
                     name, k, rdata, err, busy, dev_strb, exp_ba.size(), exp_rdata, e_err);
        end
        if (max_wait == 0) begin
            checks++;
            if (cycles != exp_ba.size() + 1) begin
                errors++;
                $display("FAIL %s latency: ack after %0d cycles, required %0d",
                         name, cycles, exp_ba.size() + 1);
            end
        end
        @(negedge sys_clk);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_ack: ack=%b busy=%b, required 0 0", name, ack, busy);
        end
    endtask

    task automatic test_reset();
        resetl = 1'b0; req = 1'b1; reads = 1'b1; ba = '0; w = '0; mws = '0; justify = 1'b0;
        wdata = '1; dev_rdata = '1; dev_ack = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({ack, busy, err, dev_strb, dev_we, dev_ba, dev_be} !== 15'h0 || rdata !== 64'h0
            || dev_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset: ack=%b busy=%b err=%b strb=%b we=%b ba=%0d be=%h rd=%h wd=%h, required all 0",
                     ack, busy, err, dev_strb, dev_we, dev_ba, dev_be, rdata, dev_wdata);
        end
        req = 1'b0; dev_ack = 1'b0; dev_rdata = '0;
        @(negedge sys_clk);
        resetl = 1'b1;
    endtask

    task automatic test_plan_cases();
        run_txn(1'b1, 3'd0, 4'd0, 2'd1, 1'b0, 64'h0, 0, 1'b1, 64'h8877665544332211, "s1_read16");
        checks++;
        if (last_rdata !== 64'h8877665544332211) begin
            errors++;
            $display("FAIL s1_const: rdata=%h, required 8877665544332211", last_rdata);
        end
        run_txn(1'b1, 3'd5, 4'd1, 2'd3, 1'b1, 64'h0, 0, 1'b1, 64'h0000A50000000000, "s2_just");
        checks++;
        if (last_rdata !== 64'h00000000000000A5) begin
            errors++;
            $display("FAIL s2_const: rdata=%h, required 00000000000000a5", last_rdata);
        end
        run_txn(1'b0, 3'd3, 4'd4, 2'd2, 1'b0, 64'h1122334455667788, 1, 1'b0, 64'h0, "s3_write");
        run_txn(1'b1, 3'd6, 4'd4, 2'd0, 1'b0, 64'h0, 2, 1'b0, 64'h0, "s4_trunc");
        checks++;
        if (last_err !== 1'b1) begin
            errors++;
            $display("FAIL s4_err: err=%b, required 1", last_err);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge sys_clk);
        req = 1'b1; reads = 1'b1; ba = 3'd0; w = 4'd0; mws = 2'd1; justify = 1'b0;
        @(negedge sys_clk);
        req = 1'b0; dev_ack = 1'b1; dev_rdata = 64'h8877665544332211;
        @(negedge sys_clk);
        checks++;
        if (dev_strb !== 1'b1 || dev_ba !== 3'd2) begin
            errors++;
            $display("FAIL midrst_beat2: strb=%b ba=%0d, required 1 2", dev_strb, dev_ba);
        end
        dev_ack = 1'b0; resetl = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (dev_strb !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: strb=%b busy=%b ack=%b, required 0 0 0",
                     dev_strb, busy, ack);
        end
        resetl = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            checks++;
            if (ack !== 1'b0 || dev_strb !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet%0d: ack=%b strb=%b, required 0 0", i, ack, dev_strb);
            end
        end
        run_txn(1'b1, 3'd0, 4'd0, 2'd1, 1'b0, 64'h0, 1, 1'b0, 64'h0, "midrst_restart");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 3'($urandom), 4'($urandom_range(8, 0)), 2'($urandom),
                    1'($urandom), {$urandom, $urandom}, int'($urandom_range(3, 0)), 1'b0,
                    64'h0, $sformatf("rand%0d", t));
        end
    endtask

`ifdef BUS_PACK_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge sys_clk);
        req = 1'b1; reads = 1'b1; ba = 3'd0; w = 4'd4; mws = 2'd1; justify = 1'b0;
        @(negedge sys_clk);
        req = 1'b0; dev_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dev_strb !== 1'b1) begin
                errors++;
                $display("FAIL tmo_strb%0d: strb=%b, required 1", i, dev_strb);
            end
            @(negedge sys_clk);
        end
        checks++;
        if (dev_strb !== 1'b0 || ack !== 1'b1 || err !== 1'b1 || rdata !== 64'h00000000FFFFFFFF) begin
            errors++;
            $display("FAIL tmo_done: strb=%b ack=%b err=%b rdata=%h, required 0 1 1 00000000ffffffff",
                     dev_strb, ack, err, rdata);
        end
        @(negedge sys_clk);
    endtask
`endif

    initial begin
        test_reset();
        test_plan_cases();
        test_mid_reset();
        test_random();
`ifdef BUS_PACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
